// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART transmit path.
package spart_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    WAIT_LO = 2'd2,
    WAIT_HI = 2'd3
  } txq_state_t;

  localparam logic [31:0] SPART_TX_ADDR   = 32'h1000_0000;
  localparam logic [31:0] SPART_STAT_ADDR = 32'h1000_0004;
  localparam logic [15:0] SPART_DIV_38400 = 16'h0a2c;

endpackage

// File: rtl/spart_tx_queue_if.sv
// CPU-store / spart_tx side signals of the transmit queue.
interface spart_tx_queue_if #(
  parameter int AW = 4
);
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        TBR;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        full;
  logic        empty;
  logic [AW:0] count;
  logic        ovf;
  logic        stall;

  modport master (
    output wr_en, wr_data, TBR,
    input  trmt, tx_data, full, empty, count, ovf, stall
  );

  modport slave (
    input  wr_en, wr_data, TBR,
    output trmt, tx_data, full, empty, count, ovf, stall
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO; the popped word is captured in a register and held until the next pop.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [AW:0]      count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] rdata_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_i) wptr_d = wptr_q + 1'b1;
    if (pop_i)  rptr_d = rptr_q + 1'b1;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // On a full-queue push+pop wptr==rptr: the read sees the old head before the overwrite.
  always_ff @(posedge clk) begin
    if (push_i) mem[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      rdata_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      if (pop_i) rdata_q <= mem[rptr_q];
    end
  end

  assign rdata_o = rdata_q;
  assign count_o = count_q;
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/spart_tx_queue.sv
// Byte queue from CPU stores into spart_tx via the trmt/TBR handshake.
// Build option SPART_TXQ_STALL_EN: stall the CPU on a full queue instead of dropping bytes.
module spart_tx_queue
  import spart_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int LOW_TMO = 4
) (
  input logic             clk,
  input logic             rst,
  spart_tx_queue_if.slave bus
);

  localparam int TW = $clog2(LOW_TMO + 1);

  txq_state_t    state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          trmt_q, trmt_d;
  logic          ovf_q, ovf_d;
  logic          pop, push;
  logic          fifo_full, fifo_empty;
  logic [AW:0]   fifo_count;
  logic [7:0]    head_byte;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8),
    .AW    (AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (bus.wr_data),
    .rdata_o (head_byte),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign push = bus.wr_en && (!fifo_full || pop);

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    trmt_d  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && bus.TBR) begin
          pop     = 1'b1;
          trmt_d  = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        tmo_d   = '0;
        state_d = WAIT_LO;
      end
      // If TBR never drops, assume spart_tx absorbed the byte and move on.
      WAIT_LO: begin
        if (!bus.TBR)                          state_d = WAIT_HI;
        else if (tmo_q == TW'(LOW_TMO - 1))    state_d = IDLE;
        else                                   tmo_d   = tmo_q + 1'b1;
      end
      WAIT_HI: begin
        if (bus.TBR) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SPART_TXQ_STALL_EN
  // A refused store is held by the CPU and retried, so nothing is ever lost.
  assign ovf_d     = ovf_q;
  assign bus.stall = fifo_full && bus.wr_en;
`else
  assign ovf_d     = ovf_q | (bus.wr_en && fifo_full && !pop);
  assign bus.stall = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tmo_q   <= '0;
      trmt_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      trmt_q  <= trmt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.trmt    = trmt_q;
  assign bus.tx_data = head_byte;
  assign bus.full    = fifo_full;
  assign bus.empty   = fifo_empty;
  assign bus.count   = fifo_count;
  assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_spart_tx_queue.sv
// Directed bench for spart_tx_queue: latency, ordering, overflow, timeout and reset.
module tb_spart_tx_queue;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tbr_man = 1'b0;
  logic model_en = 1'b0;
  logic tbr_model = 1'b1;
  int   busy_len = 100;
  int   busy_cnt = 0;
  int   width_err = 0;
  logic prev_trmt = 1'b0;
  logic [7:0] got[$];

  int tests_run = 0;
  int tests_failed = 0;

  spart_tx_queue_if #(.AW(4)) txq_bus ();

  assign txq_bus.TBR = model_en ? tbr_model : tbr_man;

  spart_tx_queue #(
    .DEPTH   (16),
    .AW      (4),
    .LOW_TMO (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (txq_bus)
  );

  always #5 clk = ~clk;

  // spart_tx stand-in: TBR drops on trmt and rises again busy_len cycles later.
  always @(negedge clk) begin
    if (!model_en) begin
      tbr_model <= 1'b1;
      busy_cnt  <= 0;
    end else if (txq_bus.trmt) begin
      tbr_model <= 1'b0;
      busy_cnt  <= busy_len;
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end else if (busy_cnt == 1) begin
      busy_cnt  <= 0;
      tbr_model <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (txq_bus.trmt) begin
      got.push_back(txq_bus.tx_data);
      $display("[TB] trmt byte %02h", txq_bus.tx_data);
      if (prev_trmt) width_err <= width_err + 1;
    end
    prev_trmt <= txq_bus.trmt;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    txq_bus.wr_en = 1'b0;
    txq_bus.wr_data = 8'h00;
    tick();
    tick();
    tests_run++; if (txq_bus.trmt !== 1'b0) begin tests_failed++; $display("FAIL reset_trmt got %b exp 0", txq_bus.trmt); end
    tests_run++; if (txq_bus.tx_data !== 8'h00) begin tests_failed++; $display("FAIL reset_tx_data got %h exp 00", txq_bus.tx_data); end
    tests_run++; if (txq_bus.count !== 5'd0) begin tests_failed++; $display("FAIL reset_count got %0d exp 0", txq_bus.count); end
    tests_run++; if (txq_bus.empty !== 1'b1 || txq_bus.full !== 1'b0) begin tests_failed++; $display("FAIL reset_flags got empty=%b full=%b exp 1 0", txq_bus.empty, txq_bus.full); end
    tests_run++; if (txq_bus.ovf !== 1'b0 || txq_bus.stall !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf_stall got %b %b exp 0 0", txq_bus.ovf, txq_bus.stall); end
    rst = 1'b0;
    tick();
    $display("[TB] test_reset done");
  endtask

  task automatic test_single();
    tbr_man = 1'b1;
    txq_bus.wr_en = 1'b1; txq_bus.wr_data = 8'h41;
    tick();
    txq_bus.wr_en = 1'b0;
    tests_run++; if (txq_bus.count !== 5'd1 || txq_bus.trmt !== 1'b0) begin tests_failed++; $display("FAIL single_n1 got count=%0d trmt=%b exp 1 0", txq_bus.count, txq_bus.trmt); end
    tick();
    tests_run++; if (txq_bus.trmt !== 1'b1 || txq_bus.tx_data !== 8'h41) begin tests_failed++; $display("FAIL single_n2 got trmt=%b data=%h exp 1 41", txq_bus.trmt, txq_bus.tx_data); end
    tests_run++; if (txq_bus.empty !== 1'b1) begin tests_failed++; $display("FAIL single_empty got %b exp 1", txq_bus.empty); end
    tick();
    tests_run++; if (txq_bus.trmt !== 1'b0 || txq_bus.tx_data !== 8'h41) begin tests_failed++; $display("FAIL single_n3 got trmt=%b data=%h exp 0 41", txq_bus.trmt, txq_bus.tx_data); end
    repeat (8) tick();
    $display("[TB] test_single done");
  endtask

  task automatic test_timeout();
    int highs = 0;
    tbr_man = 1'b1;
    txq_bus.wr_en = 1'b1; txq_bus.wr_data = 8'h5A;
    tick();
    txq_bus.wr_data = 8'h5B;
    tick();
    txq_bus.wr_en = 1'b0;
    tests_run++; if (txq_bus.trmt !== 1'b1 || txq_bus.tx_data !== 8'h5A) begin tests_failed++; $display("FAIL tmo_first got trmt=%b data=%h exp 1 5a", txq_bus.trmt, txq_bus.tx_data); end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (txq_bus.trmt) highs++;
    end
    tests_run++; if (highs != 0) begin tests_failed++; $display("FAIL tmo_gap got %0d trmt cycles exp 0", highs); end
    tick();
    tests_run++; if (txq_bus.trmt !== 1'b1 || txq_bus.tx_data !== 8'h5B) begin tests_failed++; $display("FAIL tmo_second got trmt=%b data=%h exp 1 5b", txq_bus.trmt, txq_bus.tx_data); end
    repeat (10) tick();
    $display("[TB] test_timeout done");
  endtask

  task automatic test_order();
    logic [23:0] seen = '0;
    tbr_man = 1'b0;
    got.delete();
    for (int i = 1; i <= 3; i++) begin
      txq_bus.wr_en = 1'b1; txq_bus.wr_data = 8'(i);
      tick();
    end
    txq_bus.wr_en = 1'b0;
    tests_run++; if (txq_bus.count !== 5'd3) begin tests_failed++; $display("FAIL order_count got %0d exp 3", txq_bus.count); end
    busy_len = 100;
    model_en = 1'b1;
    for (int c = 0; c < 600 && got.size() < 3; c++) tick();
    for (int i = 0; i < 3 && i < got.size(); i++) seen = {seen[15:0], got[i]};
    tests_run++; if (got.size() != 3 || seen !== 24'h010203) begin tests_failed++; $display("FAIL order_bytes got n=%0d %h exp n=3 010203", got.size(), seen); end
    tests_run++; if (width_err != 0) begin tests_failed++; $display("FAIL order_trmt_width got %0d long pulses exp 0", width_err); end
    repeat (110) tick();
    model_en = 1'b0;
    tbr_man = 1'b0;
    tick();
    $display("[TB] test_order done");
  endtask

  task automatic test_full();
    for (int i = 0; i < 16; i++) begin
      txq_bus.wr_en = 1'b1; txq_bus.wr_data = 8'h10 + 8'(i);
      tick();
    end
    txq_bus.wr_en = 1'b0;
    tests_run++; if (txq_bus.full !== 1'b1 || txq_bus.count !== 5'd16) begin tests_failed++; $display("FAIL full_flags got full=%b count=%0d exp 1 16", txq_bus.full, txq_bus.count); end
    tests_run++; if (txq_bus.ovf !== 1'b0) begin tests_failed++; $display("FAIL full_ovf_pre got %b exp 0", txq_bus.ovf); end
    txq_bus.wr_en = 1'b1; txq_bus.wr_data = 8'hEE;
    #1;
`ifdef SPART_TXQ_STALL_EN
    tests_run++; if (txq_bus.stall !== 1'b1) begin tests_failed++; $display("FAIL full_stall got %b exp 1", txq_bus.stall); end
`else
    tests_run++; if (txq_bus.stall !== 1'b0) begin tests_failed++; $display("FAIL full_stall got %b exp 0", txq_bus.stall); end
`endif
    tick();
    txq_bus.wr_en = 1'b0;
`ifdef SPART_TXQ_STALL_EN
    tests_run++; if (txq_bus.ovf !== 1'b0) begin tests_failed++; $display("FAIL full_ovf got %b exp 0", txq_bus.ovf); end
`else
    tests_run++; if (txq_bus.ovf !== 1'b1) begin tests_failed++; $display("FAIL full_ovf got %b exp 1", txq_bus.ovf); end
`endif
    tests_run++; if (txq_bus.count !== 5'd16) begin tests_failed++; $display("FAIL full_count got %0d exp 16", txq_bus.count); end
    $display("[TB] test_full done");
  endtask

  task automatic test_full_push_pop();
    int bad = 0;
    logic [7:0] exp;
    got.delete();
    tbr_man = 1'b1;
    txq_bus.wr_en = 1'b1; txq_bus.wr_data = 8'hAB;
    tick();
    txq_bus.wr_en = 1'b0;
    tests_run++; if (txq_bus.count !== 5'd16) begin tests_failed++; $display("FAIL pushpop_count got %0d exp 16", txq_bus.count); end
    tests_run++; if (txq_bus.trmt !== 1'b1 || txq_bus.tx_data !== 8'h10) begin tests_failed++; $display("FAIL pushpop_head got trmt=%b data=%h exp 1 10", txq_bus.trmt, txq_bus.tx_data); end
    busy_len = 20;
    model_en = 1'b1;
    for (int c = 0; c < 1000 && got.size() < 17; c++) tick();
    for (int i = 0; i < 17 && i < got.size(); i++) begin
      exp = (i < 16) ? 8'h10 + 8'(i) : 8'hAB;
      if (got[i] !== exp) bad++;
    end
    tests_run++; if (got.size() != 17 || bad != 0) begin tests_failed++; $display("FAIL pushpop_drain got n=%0d wrong=%0d exp n=17 wrong=0", got.size(), bad); end
    tests_run++; if (txq_bus.empty !== 1'b1) begin tests_failed++; $display("FAIL pushpop_empty got %b exp 1", txq_bus.empty); end
    repeat (30) tick();
    model_en = 1'b0;
    tbr_man = 1'b1;
    tick();
    $display("[TB] test_full_push_pop done");
  endtask

  task automatic test_reset_mid();
    tbr_man = 1'b1;
    for (int i = 0; i < 6; i++) begin
      txq_bus.wr_en = 1'b1; txq_bus.wr_data = 8'h60 + 8'(i);
      tick();
      if (i == 2) tbr_man = 1'b0;
    end
    txq_bus.wr_en = 1'b0;
    tests_run++; if (txq_bus.count !== 5'd5) begin tests_failed++; $display("FAIL midrst_pre_count got %0d exp 5", txq_bus.count); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++; if (txq_bus.count !== 5'd0 || txq_bus.empty !== 1'b1) begin tests_failed++; $display("FAIL midrst_count got %0d empty=%b exp 0 1", txq_bus.count, txq_bus.empty); end
    tests_run++; if (txq_bus.trmt !== 1'b0 || txq_bus.tx_data !== 8'h00) begin tests_failed++; $display("FAIL midrst_out got trmt=%b data=%h exp 0 00", txq_bus.trmt, txq_bus.tx_data); end
    tests_run++; if (txq_bus.ovf !== 1'b0) begin tests_failed++; $display("FAIL midrst_ovf got %b exp 0", txq_bus.ovf); end
    tbr_man = 1'b1;
    txq_bus.wr_en = 1'b1; txq_bus.wr_data = 8'h77;
    tick();
    txq_bus.wr_en = 1'b0;
    tick();
    tests_run++; if (txq_bus.trmt !== 1'b1 || txq_bus.tx_data !== 8'h77) begin tests_failed++; $display("FAIL midrst_resume got trmt=%b data=%h exp 1 77", txq_bus.trmt, txq_bus.tx_data); end
    repeat (8) tick();
    $display("[TB] test_reset_mid done");
  endtask

  initial begin
    txq_bus.wr_en = 1'b0;
    txq_bus.wr_data = 8'h00;
    test_reset();
    test_single();
    test_timeout();
    test_order();
    test_full();
    test_full_push_pop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
